// File: rtl/dac_sigdel_p2.sv
// dac_sigdel_p2: parametrised 2nd-order 1-bit sigma-delta DAC with LFSR dither and OSR-paced sample input
module dac_sigdel_p2 #(
  parameter int DW = 16,
  parameter int NW = 4,
  parameter int OSR = 64,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_sd,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          dither_en,
  input  logic          stat_clr,
  output logic          sd_out,
  output logic          ovld,
  output logic          udrn
);
  localparam int CW = $clog2(OSR);
  logic [CW-1:0] cnt;
  logic [15:0] lfsr;
  logic [DW-1:0] act, pend;
  logic pend_full, wrap, under, innoise, q, ovf1, ovf2;
  logic [NW-1:0] noise;
  logic [8:0] s5;
  logic [DW:0] s1;
  logic [DW+3:0] s2;
  logic [DW+2:0] s3, s4, z1_n;
  logic [DW+1:0] z2_n;
  logic signed [DW+2:0] z1;
  logic signed [DW+1:0] z2;
  // All datapath arithmetic is two's-complement on explicit bit vectors, so widths wrap exactly as sized
  always_comb begin
    wrap = cnt == CW'(OSR - 1);
    under = wrap & ~pend_full & ~din_valid;
    din_ready = ~pend_full;
    noise = dither_en ? lfsr[NW-1:0] : '0;
    innoise = dither_en & lfsr[15];
    s5 = {z2[DW+1], z2[DW+1:DW-6]} + {{(9-NW){noise[NW-1]}}, noise};
    q = ~s5[8];
    s1 = {1'b0, act} + (DW+1)'(innoise) - {q, {DW{1'b0}}};
    s2 = {{3{s1[DW]}}, s1} + {z1[DW+2], z1};
    ovf1 = s2[DW+3] != s2[DW+2];
    z1_n = ovf1 ? {s2[DW+3], {(DW+2){~s2[DW+3]}}} : s2[DW+2:0];
    s3 = {z1[DW+2], z1[DW+2:1]} - {2'b00, q, {DW{1'b0}}};
    s4 = s3 + {z2[DW+1], z2};
    ovf2 = s4[DW+2] != s4[DW+1];
    z2_n = ovf2 ? {s4[DW+2], {(DW+1){~s4[DW+2]}}} : s4[DW+1:0];
  end
  always_ff @(posedge clk or posedge rst_sd) begin
    if (rst_sd) begin
      cnt <= '0;
      lfsr <= SEED;
      act <= {1'b1, {(DW-1){1'b0}}};
      pend <= '0;
      pend_full <= 1'b0;
      z1 <= '0;
      z2 <= '0;
      sd_out <= 1'b0;
      ovld <= 1'b0;
      udrn <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      z1 <= z1_n;
      z2 <= z2_n;
      sd_out <= q;
      ovld <= ovf1 | ovf2 | (ovld & ~stat_clr);
      udrn <= under | (udrn & ~stat_clr);
      if (wrap) begin
        if (pend_full) act <= pend;
        else if (din_valid) act <= din;
        pend_full <= 1'b0;
      end else if (din_valid && !pend_full) begin
        pend <= din;
        pend_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dac_sigdel_p2.sv
// tb_dac_sigdel_p2: vector table, accept/load scoreboard and cycle reference model for dac_sigdel_p2
module tb_dac_sigdel_p2;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int OSR = 4;
  logic clk = 1'b0;
  logic rst_sd = 1'b0;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic dither_en = 1'b0;
  logic stat_clr = 1'b0;
  logic din_ready, sd_out, ovld, udrn;
  always #5 clk = ~clk;
  dac_sigdel_p2 #(.DW(DW), .NW(NW), .OSR(OSR), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_sd(rst_sd), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dither_en(dither_en), .stat_clr(stat_clr), .sd_out(sd_out), .ovld(ovld), .udrn(udrn)
  );
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic chk_rng(input string name, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask
  function automatic longint wrapn(input longint v, input int n);
    longint m = longint'(1) << n;
    longint r = v & (m - 1);
    return (r >= (m >> 1)) ? r - m : r;
  endfunction
  function automatic longint satn(input longint v, input int n);
    longint hi = (longint'(1) << (n - 1)) - 1;
    longint lo = -(longint'(1) << (n - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
  // Reference model written directly from the modulator equations in integer arithmetic
  int m_cnt, m_clamps = 0;
  logic [15:0] m_lfsr, m_act, m_pend;
  logic m_pf, m_sd, m_ovld, m_udrn, m_load;
  longint m_z1, m_z2, nz, inn, fb, r1, r2, t1, t2;
  bit mq, wr, clamp;
  always @(posedge clk or posedge rst_sd) begin
    if (rst_sd) begin
      m_cnt <= 0;
      m_lfsr <= 16'hACE1;
      m_act <= 16'h8000;
      m_pend <= '0;
      m_pf <= 1'b0;
      m_z1 <= 0;
      m_z2 <= 0;
      m_sd <= 1'b0;
      m_ovld <= 1'b0;
      m_udrn <= 1'b0;
      m_load <= 1'b0;
    end else begin
      nz = dither_en ? wrapn(longint'(m_lfsr[NW-1:0]), NW) : 0;
      inn = dither_en ? longint'(m_lfsr[15]) : 0;
      mq = ((m_z2 >>> (DW - 6)) + nz) >= 0;
      fb = mq ? (longint'(1) << DW) : 0;
      r1 = wrapn(longint'(m_act) + inn - fb, DW + 1) + m_z1;
      r2 = wrapn((m_z1 >>> 1) - fb + m_z2, DW + 3);
      t1 = satn(r1, DW + 3);
      t2 = satn(r2, DW + 2);
      clamp = (t1 != r1) || (t2 != r2);
      wr = m_cnt == OSR - 1;
      m_z1 <= t1;
      m_z2 <= t2;
      m_sd <= mq;
      m_ovld <= clamp || (m_ovld && !stat_clr);
      m_udrn <= (wr && !m_pf && !din_valid) || (m_udrn && !stat_clr);
      m_clamps <= m_clamps + (clamp ? 1 : 0);
      m_load <= wr && (m_pf || din_valid);
      m_cnt <= wr ? 0 : m_cnt + 1;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (wr) begin
        if (m_pf) m_act <= m_pend;
        else if (din_valid) m_act <= din;
        m_pf <= 1'b0;
      end else if (din_valid && !m_pf) begin
        m_pend <= din;
        m_pf <= 1'b1;
      end
    end
  end
  int trace_err = 0;
  always @(negedge clk) begin
    if (!rst_sd) begin
      if (sd_out !== m_sd || din_ready !== !m_pf || ovld !== m_ovld || udrn !== m_udrn ||
          longint'(dut.z1) != m_z1 || longint'(dut.z2) != m_z2 || dut.act !== m_act || dut.lfsr !== m_lfsr)
        trace_err++;
    end
  end
  // Scoreboard: every accepted sample must reach act exactly once, in order
  logic [15:0] sb[$];
  logic [15:0] sb_exp;
  int n_acc = 0;
  always @(posedge clk) begin
    if (!rst_sd && din_valid && din_ready) begin
      sb.push_back(din);
      n_acc++;
    end
  end
  always @(negedge clk) begin
    if (!rst_sd && m_load) begin
      if (sb.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        sb_exp = sb.pop_front();
        chk("sb_act", dut.act, sb_exp);
      end
    end
  end
  task automatic wait_cnt(input int c);
    int n = 0;
    while (m_cnt != c && n < 4 * OSR) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt != c) chk("sync", m_cnt, c);
  endtask
  typedef struct {
    logic [15:0] din;
    logic        valid;
    logic        clr;
    logic [15:0] act;
    logic        udrn;
  } vec_t;
  vec_t tv[10];
  int a0, e0, ones, c0;
  initial begin
    tv[0] = '{16'h1000, 1'b1, 1'b1, 16'h1000, 1'b0};
    tv[1] = '{16'h1001, 1'b1, 1'b0, 16'h1001, 1'b0};
    tv[2] = '{16'h1002, 1'b1, 1'b0, 16'h1002, 1'b0};
    tv[3] = '{16'h1003, 1'b1, 1'b0, 16'h1003, 1'b0};
    tv[4] = '{16'h1004, 1'b1, 1'b0, 16'h1004, 1'b0};
    tv[5] = '{16'hDEAD, 1'b0, 1'b0, 16'h1004, 1'b1};
    tv[6] = '{16'hBEEF, 1'b0, 1'b1, 16'h1004, 1'b1};
    tv[7] = '{16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0};
    tv[8] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    tv[9] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    #1 rst_sd = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sd_out", sd_out, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_ovld", ovld, 0);
    chk("rst_udrn", udrn, 0);
    chk("rst_act", dut.act, 16'h8000);
    chk("rst_lfsr", dut.lfsr, 16'hACE1);
    rst_sd = 1'b0;
    e0 = trace_err;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      wait_cnt(0);
      din = tv[i].din;
      din_valid = tv[i].valid;
      wait_cnt(OSR - 1);
      stat_clr = tv[i].clr;
      @(negedge clk);
      stat_clr = 1'b0;
      chk($sformatf("tbl_act_%0d", i), dut.act, tv[i].act);
      chk($sformatf("tbl_udrn_%0d", i), udrn, tv[i].udrn);
      if (i == 4) chk("tbl_accepts", n_acc - a0, 5);
    end
    din_valid = 1'b0;
    wait_cnt(0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    wait_cnt(OSR - 1);
    din = 16'h5555;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("bypass_act", dut.act, 16'h5555);
    chk("bypass_udrn", udrn, 0);
    chk("bypass_ready", din_ready, 1);
    chk("trace_handshake", trace_err - e0, 0);
    din = 16'h7777;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("pend_full_pre", din_ready, 0);
    #2 rst_sd = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_sd_out", sd_out, 0);
    chk("mid_rst_ready", din_ready, 1);
    chk("mid_rst_ovld", ovld, 0);
    chk("mid_rst_udrn", udrn, 0);
    chk("mid_rst_lfsr", dut.lfsr, 16'hACE1);
    @(negedge clk);
    rst_sd = 1'b0;
    repeat (OSR - 1) @(negedge clk);
    chk("post_rst_udrn_pre", udrn, 0);
    @(negedge clk);
    chk("post_rst_udrn", udrn, 1);
    chk("post_rst_act", dut.act, 16'h8000);
    e0 = trace_err;
    din = 16'h4000;
    din_valid = 1'b1;
    repeat (1024) @(negedge clk);
    ones = 0;
    repeat (16384) @(negedge clk) ones += int'(sd_out);
    chk_rng("density_4000", ones, 4096 - 16, 4096 + 16);
    din = 16'h8000;
    repeat (1024) @(negedge clk);
    ones = 0;
    repeat (16384) @(negedge clk) ones += int'(sd_out);
    chk_rng("density_8000", ones, 8192 - 16, 8192 + 16);
    chk("trace_density", trace_err - e0, 0);
    e0 = trace_err;
    c0 = m_clamps;
    din = 16'hFFFF;
    dither_en = 1'b1;
    repeat (8192) @(negedge clk);
    chk("trace_overload", trace_err - e0, 0);
    chk("ovld_sticky", ovld, (m_clamps > c0) ? 1 : 0);
    din = 16'h8000;
    dither_en = 1'b0;
    repeat (512) @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("ovld_clr", ovld, m_ovld);
    chk("udrn_clr", udrn, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
